cdc_toggle_monitor: RTL
=======================

Name: cdc_toggle_monitor

Overview:
- Consumes the 1-bit toggle stream produced by the Aclk→Bclk crossing stage; runs entirely in the Bclk domain.
- Detects each toggle (one per Aclk-domain event) and counts them over fixed windows of WIN_LEN Bclk cycles.
- Presents each window total on a valid/ready output to downstream logic.
- Flags count saturation and snapshots dropped by back-pressure.

Parameters:
- CNT_W, 8, width of the event count; saturates at 2^CNT_W-1.
- WIN_LEN, 256, window length in Bclk cycles; legal range ≥2. Timer width is ceil(log2(WIN_LEN)).

Ports:
- Bclk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Din  input  1  toggle stream from the crossing stage, already synchronous to Bclk.
- en  input  1  1 = monitor runs; 0 = idle.
- clear  input  1  synchronous clear of counters, output and flags.
- cnt_out  output  CNT_W  window event count; stable while cnt_valid=1.
- cnt_valid  output  1  cnt_out holds an untransferred snapshot.
- cnt_ready  input  1  downstream accepts cnt_out.
- overflow  output  1  sticky: some window saturated.
- dropped  output  1  sticky: a snapshot was discarded because the output was full.

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE; d_q=0; count=0; timer=0.
  - cnt_out=0; cnt_valid=0; overflow=0; dropped=0.
- Priority per cycle: reset > clear > state logic.
- clear=1:
  - Next state IDLE; count, timer, cnt_out cleared; cnt_valid, overflow, dropped cleared.
  - Any pending snapshot is lost.
- States:
  - IDLE: count and timer held at 0; d_q<=Din. en=1 → PRIME.
  - PRIME: one cycle; d_q<=Din so the first compare never sees a stale level; no counting. en=0 → IDLE, else → RUN.
  - RUN: en=0 → IDLE; the partial window is discarded and no snapshot is taken.
- RUN datapath, per cycle:
  - edge = Din XOR d_q; d_q<=Din.
  - nxt = count + edge, saturating at 2^CNT_W-1. If the add would exceed max, overflow<=1.
  - If timer<WIN_LEN-1: timer<=timer+1; count<=nxt.
  - If timer==WIN_LEN-1 (terminal): snapshot=nxt; count<=0; timer<=0. An edge in the terminal cycle belongs to the closing window.
- Window timing:
  - Window 0 starts at the first RUN cycle.
  - Each window spans exactly WIN_LEN RUN cycles.
  - cnt_valid rises on the clock edge that ends the terminal cycle, i.e. latency 1 after the terminal cycle.
- Output handshake:
  - Transfer occurs when cnt_valid & cnt_ready at a rising edge.
  - cnt_out must not change while cnt_valid=1 without a transfer.
  - Snapshot while cnt_valid=0: cnt_out<=snapshot; cnt_valid<=1.
  - Snapshot while transfer in the same cycle: cnt_out<=snapshot; cnt_valid stays 1; no drop.
  - Snapshot while cnt_valid=1 and cnt_ready=0: old cnt_out kept; snapshot discarded; dropped<=1.
  - Transfer without snapshot: cnt_valid<=0; cnt_out keeps its last value.
  - The handshake keeps operating in IDLE and PRIME; a pending snapshot survives en=0.
- Sticky flags: overflow and dropped clear only on reset or clear.
- Reset mid-window: all state lost immediately; after release, counting restarts via IDLE → PRIME.

Test Plan:
- Basic count (WIN_LEN=16, CNT_W=8, cnt_ready=1): en=1 held; Din toggles every 2 cycles from the first RUN cycle → cnt_out=8, cnt_valid pulses 1 cycle, 17 cycles after PRIME; repeats every 16 cycles; overflow=0.
- Prime suppression: Din=1 held before en rises, no toggles → cnt_out=0 each window; no spurious count of 1.
- Saturation (CNT_W=3, WIN_LEN=16): Din toggles every cycle (16 edges) → cnt_out=7, overflow=1 and stays 1; clear=1 → overflow=0, cnt_valid=0, state IDLE.
- Back-pressure (WIN_LEN=16, cnt_ready=0):
  - Window 1 has 4 edges, window 2 has 6 → cnt_out stays 4, cnt_valid=1, dropped=1.
  - Then raise cnt_ready for 1 cycle → transfer, cnt_valid=0.
- Simultaneous transfer and snapshot: cnt_ready=1 exactly on the cycle window 2 snapshots (5 edges) → cnt_out 4→5, cnt_valid stays 1, dropped=0.
- Disruption mid-window:
  - en=0 at window cycle 9 → no snapshot; en=1 again → PRIME, then a fresh 16-cycle window.
  - Async reset asserted mid-window → all outputs 0 within the same cycle, independent of Bclk.

Source files
------------

// File: rtl/cdc_toggle_monitor.sv
// Bclk-domain monitor for the Aclk->Bclk toggle stream: counts toggles per
// WIN_LEN-cycle window and offers each total on a valid/ready output.
module cdc_toggle_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 256
) (
  input  logic             Bclk,
  input  logic             reset,
  input  logic             Din,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overflow,
  output logic             dropped
);

  localparam int               TMR_W    = $clog2(WIN_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             d_q_r;
  logic [CNT_W-1:0] count_r;
  logic [TMR_W-1:0] timer_r;
  logic [CNT_W-1:0] cnt_out_r;
  logic             cnt_valid_r;
  logic             overflow_r;
  logic             dropped_r;

  logic             run_s;
  logic             edge_s;
  logic             sat_s;
  logic [CNT_W-1:0] nxt_s;
  logic             terminal_s;
  logic             xfer_s;

  assign cnt_out   = cnt_out_r;
  assign cnt_valid = cnt_valid_r;
  assign overflow  = overflow_r;
  assign dropped   = dropped_r;

  // Edge detect, saturating increment and window/handshake qualifiers.
  always_comb begin
    run_s      = (state_r == ST_RUN) && en;
    edge_s     = Din ^ d_q_r;
    sat_s      = 1'b0;
    nxt_s      = count_r;
    if (edge_s && (count_r == CNT_MAX)) begin
      sat_s = 1'b1;
      nxt_s = count_r;
    end else begin
      sat_s = 1'b0;
      nxt_s = count_r + CNT_W'(edge_s);
    end
    terminal_s = run_s && (timer_r == TMR_LAST);
    xfer_s     = cnt_valid_r && cnt_ready;
  end

  // Next-state decode; leaving RUN with en low abandons the partial window.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) state_nxt_s = ST_PRIME;
        else    state_nxt_s = ST_IDLE;
      end
      ST_PRIME: begin
        if (en) state_nxt_s = ST_RUN;
        else    state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (en) state_nxt_s = ST_RUN;
        else    state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and previous-level sample of the toggle stream.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      d_q_r   <= 1'b0;
    end else if (clear) begin
      state_r <= ST_IDLE;
      d_q_r   <= Din;
    end else begin
      state_r <= state_nxt_s;
      d_q_r   <= Din;
    end
  end

  // Window counter and timer; both sit at zero outside RUN.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
      timer_r <= '0;
    end else if (clear) begin
      count_r <= CNT_ZERO;
      timer_r <= '0;
    end else if (run_s) begin
      if (terminal_s) begin
        count_r <= CNT_ZERO;
        timer_r <= '0;
      end else begin
        count_r <= nxt_s;
        timer_r <= timer_r + TMR_ONE;
      end
    end else begin
      count_r <= CNT_ZERO;
      timer_r <= '0;
    end
  end

  // Output slot: the terminal-cycle total (including its own edge) lands
  // here unless an untransferred snapshot is still being held.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      cnt_out_r   <= CNT_ZERO;
      cnt_valid_r <= 1'b0;
      dropped_r   <= 1'b0;
    end else if (clear) begin
      cnt_out_r   <= CNT_ZERO;
      cnt_valid_r <= 1'b0;
      dropped_r   <= 1'b0;
    end else if (terminal_s) begin
      if (!cnt_valid_r || xfer_s) begin
        cnt_out_r   <= nxt_s;
        cnt_valid_r <= 1'b1;
      end else begin
        dropped_r   <= 1'b1;
      end
    end else if (xfer_s) begin
      cnt_valid_r <= 1'b0;
    end else begin
      cnt_valid_r <= cnt_valid_r;
    end
  end

  // Sticky saturation flag.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (clear) begin
      overflow_r <= 1'b0;
    end else if (run_s && sat_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule
